// File: rtl/aes_inv_round_seq_if.sv
// Valid/ready bundle for the iterative AES inverse round engine.
// States are [col][row] byte arrays.
interface aes_inv_round_seq_if;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [0:3][0:3][7:0] state_in;
  logic [0:3][0:3][7:0] key_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:3][0:3][7:0] state_out;

  modport master (
    output in_valid, in_last, state_in, key_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, in_last, state_in, key_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/aes_inv_round_seq.sv
// Iterative AES decrypt round: InvShiftRows+InvSubBytes+AddRoundKey in one cycle,
// then InvMixColumns one column per clock unless this is the final round.
module aes_inv_round_seq (
  input logic              clk,
  input logic              rst_n,
  aes_inv_round_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_colCnt;
  logic                 r_last;
  logic [0:3][0:3][7:0] r_work;
  logic [0:3][0:3][7:0] r_key;
  logic [0:3][0:3][7:0] w_sub;
  logic [0:3][7:0]      w_col;
  logic [0:3][7:0]      w_mix;
  logic                 w_inReady;
  logic                 w_outValid;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3 built from shared doubling chains
  function automatic logic [7:0] invMixByte(input logic [7:0] a0, a1, a2, a3);
    logic [7:0] x2a0, x4a0, x8a0, x2a1, x8a1, x4a2, x8a2, x8a3;
    x2a0 = xtime(a0); x4a0 = xtime(x2a0); x8a0 = xtime(x4a0);
    x2a1 = xtime(a1); x8a1 = xtime(xtime(x2a1));
    x4a2 = xtime(xtime(a2)); x8a2 = xtime(x4a2);
    x8a3 = xtime(xtime(xtime(a3)));
    return (x8a0 ^ x4a0 ^ x2a0) ^ (x8a1 ^ x2a1 ^ a1) ^ (x8a2 ^ x4a2 ^ a2) ^ (x8a3 ^ a3);
  endfunction

  always_comb begin
    w_sub = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sub[c][r] = INV_SBOX[r_work[2'(c - r)][r]] ^ r_key[c][r];
      end
    end
  end

  always_comb begin
    w_col = r_work[r_colCnt];
    w_mix = '0;
    for (int r = 0; r < 4; r++) begin
      w_mix[r] = invMixByte(w_col[r], w_col[2'(r + 1)], w_col[2'(r + 2)], w_col[2'(r + 3)]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_inReady  = 1'b0;
    w_outValid = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) w_next = SUB;
      end
      SUB:  w_next = r_last ? DONE : MIX;
      MIX:  if (r_colCnt == 2'd3) w_next = DONE;
      DONE: begin
        w_outValid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The captured state lives in r_work and is transformed in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work   <= '0;
      r_key    <= '0;
      r_last   <= 1'b0;
      r_colCnt <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_work <= bus.state_in;
            r_key  <= bus.key_in;
            r_last <= bus.in_last;
          end
        end
        SUB: r_work <= w_sub;
        MIX: begin
          r_work[r_colCnt] <= w_mix;
          r_colCnt         <= r_colCnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.state_out = r_work;

endmodule
